// File: rtl/uop_pkg.sv
// uop_pkg: shared types and sizing for the uop dispatch queue.
//   INSTR_Q_DEPTH / INSTR_Q_WIDTH : queue entries and lanes per cycle
//   uop_insn                      : one decoded uop (opcode, atomic-group marks, tag)
//   uop_bundle_t                  : one decode or dispatch bundle, lane 0 oldest
package uop_pkg;

  localparam int INSTR_Q_DEPTH = 32;
  localparam int INSTR_Q_WIDTH = 4;

  localparam int LANE_CNT_W = $clog2(INSTR_Q_WIDTH + 1);
  localparam int Q_PTR_W    = $clog2(INSTR_Q_DEPTH);
  localparam int Q_CNT_W    = $clog2(INSTR_Q_DEPTH + 1);

  typedef enum logic [2:0] {
    UOP_NOP   = 3'd0,
    UOP_ADD   = 3'd1,
    UOP_SUB   = 3'd2,
    UOP_LOAD  = 3'd3,
    UOP_STORE = 3'd4,
    UOP_HLT   = 3'd5
  } uop_op_t;

  typedef struct packed {
    uop_op_t    op;
    logic       tx_begin;
    logic       tx_end;
    logic [7:0] tag;
  } uop_insn;

  typedef uop_insn [INSTR_Q_WIDTH-1:0] uop_bundle_t;

  function automatic logic is_hlt(input uop_insn u);
    return u.op == UOP_HLT;
  endfunction

endpackage

// File: rtl/uop_dispatch_scan.sv
// uop_dispatch_scan: combinational dispatch-width selection.
//   entries : the LANES oldest queue entries (entries past count are don't-care)
//   count   : queue occupancy
//   credit  : ROB credit this cycle
//   halted  : dispatch frozen after an HLT
//   n       : number of uops to dispatch from the head this cycle
module uop_dispatch_scan
  import uop_pkg::*;
#(
  parameter int LANES = INSTR_Q_WIDTH,
  parameter int CNT_W = Q_CNT_W,
  parameter int LW    = $clog2(INSTR_Q_WIDTH + 1)
) (
  input  uop_insn [LANES-1:0] entries,
  input  logic    [CNT_W-1:0] count,
  input  logic    [LW-1:0]    credit,
  input  logic                halted,
  output logic    [LW-1:0]    n
);

  // Walk lanes oldest-first. Outside a group every uop extends n; inside an
  // open group n only moves once the closing tx_end is reached, so an
  // incomplete or over-credit group leaves n just before its tx_begin.
  always_comb begin
    int   lim;
    int   n_int;
    logic in_grp;
    logic stop;
    lim = LANES;
    if (int'(count) < lim) lim = int'(count);
    if (int'(credit) < lim) lim = int'(credit);
    n_int  = 0;
    in_grp = 1'b0;
    stop   = halted;
    for (int i = 0; i < LANES; i++) begin
      if (!stop && i < lim) begin
        if (!in_grp && entries[i].tx_begin) in_grp = 1'b1;
        if (in_grp) begin
          if (entries[i].tx_end) begin
            in_grp = 1'b0;
            n_int  = i + 1;
          end
        end else begin
          n_int = i + 1;
        end
        // HLT must be the last dispatched lane.
        if (is_hlt(entries[i])) stop = 1'b1;
      end
    end
    n = LW'(n_int);
  end

endmodule

// File: rtl/uop_dispatch_queue.sv
// uop_dispatch_queue: circular uop buffer between decode and ROB/rename.
//   clk_in, rst_in (sync, active high), flush_in
//   dec_valid_in/dec_uop_in/dec_ready_out : sparse decode bundle, all-or-nothing
//   rob_credit_in                         : uops the ROB takes this cycle
//   disp_valid_out/disp_uop_out           : thermometer-coded in-order dispatch
//   occupancy_out, halted_out             : status
module uop_dispatch_queue
  import uop_pkg::*;
#(
  parameter int DEPTH = INSTR_Q_DEPTH,
  parameter int LANES = INSTR_Q_WIDTH
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic    [LANES-1:0]          dec_valid_in,
  input  uop_insn [LANES-1:0]          dec_uop_in,
  output logic                         dec_ready_out,
  input  logic    [$clog2(LANES+1)-1:0] rob_credit_in,
  output logic    [LANES-1:0]          disp_valid_out,
  output uop_insn [LANES-1:0]          disp_uop_out,
  output logic    [$clog2(DEPTH+1)-1:0] occupancy_out,
  output logic                         halted_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(LANES + 1);

  uop_insn mem [DEPTH];

  logic    [PW-1:0]    head;
  logic    [PW-1:0]    tail;
  logic    [CW-1:0]    count;
  logic                halted;

  uop_insn [LANES-1:0] head_entries;
  logic    [LW-1:0]    scan_n;
  logic    [LW-1:0]    disp_n;
  logic    [LW-1:0]    enq_n;
  logic    [PW-1:0]    enq_off [LANES];
  logic                ready;
  logic                enq_fire;
  logic                hlt_disp;

  // Pointer arithmetic wraps naturally at PW bits.
  always_comb begin
    for (int i = 0; i < LANES; i++) head_entries[i] = mem[head + PW'(i)];
  end

  uop_dispatch_scan #(
    .LANES (LANES),
    .CNT_W (CW),
    .LW    (LW)
  ) u_scan (
    .entries (head_entries),
    .count   (count),
    .credit  (rob_credit_in),
    .halted  (halted),
    .n       (scan_n)
  );

  assign ready    = (count <= CW'(DEPTH - LANES));
  assign disp_n   = (rst_in || flush_in) ? '0 : scan_n;
  assign enq_fire = ready && (|dec_valid_in) && !flush_in && !rst_in;

  // Compaction: each valid lane lands at tail + (valid lanes below it).
  always_comb begin
    enq_n = '0;
    for (int i = 0; i < LANES; i++) begin
      enq_off[i] = PW'(enq_n);
      if (dec_valid_in[i]) enq_n = enq_n + LW'(1);
    end
  end

  always_comb begin
    hlt_disp = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (LW'(i) < disp_n && is_hlt(head_entries[i])) hlt_disp = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      disp_valid_out[i] = (LW'(i) < disp_n);
      disp_uop_out[i]   = disp_valid_out[i] ? head_entries[i] : '0;
    end
  end

  assign dec_ready_out = ready && !rst_in;
  assign occupancy_out = rst_in ? '0 : count;
  assign halted_out    = halted && !rst_in;

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      head  <= head + PW'(disp_n);
      if (enq_fire) tail <= tail + PW'(enq_n);
      count <= count + (enq_fire ? CW'(enq_n) : CW'(0)) - CW'(disp_n);
      if (hlt_disp) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (dec_valid_in[i]) mem[tail + enq_off[i]] <= dec_uop_in[i];
      end
    end
  end

endmodule

// File: tb/tb_uop_dispatch_queue.sv
module tb_uop_dispatch_queue;
  import uop_pkg::*;

  localparam int L = INSTR_Q_WIDTH;
  localparam int D = INSTR_Q_DEPTH;

  logic                  clk_in = 1'b0;
  logic                  rst_in;
  logic                  flush_in;
  logic [L-1:0]          dec_valid_in;
  uop_bundle_t           dec_uop_in;
  logic                  dec_ready_out;
  logic [LANE_CNT_W-1:0] rob_credit_in;
  logic [L-1:0]          disp_valid_out;
  uop_bundle_t           disp_uop_out;
  logic [Q_CNT_W-1:0]    occupancy_out;
  logic                  halted_out;

  always #5 clk_in = ~clk_in;

  uop_dispatch_queue dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .dec_valid_in   (dec_valid_in),
    .dec_uop_in     (dec_uop_in),
    .dec_ready_out  (dec_ready_out),
    .rob_credit_in  (rob_credit_in),
    .disp_valid_out (disp_valid_out),
    .disp_uop_out   (disp_uop_out),
    .occupancy_out  (occupancy_out),
    .halted_out     (halted_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the queue contents as a plain list, oldest first.
  uop_insn    mq[$];
  bit         m_halted = 1'b0;
  logic [7:0] tag_ctr  = 8'd0;
  uop_insn    stream[$];

  function automatic uop_insn mk(input uop_op_t op, input logic b, input logic e);
    uop_insn u;
    u.op = op; u.tx_begin = b; u.tx_end = e; u.tag = tag_ctr;
    tag_ctr++;
    return u;
  endfunction

  function automatic uop_bundle_t bndl(input uop_insn a, input uop_insn b, input uop_insn c, input uop_insn d);
    uop_bundle_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Largest legal dispatch width: whole groups only, stop after HLT.
  function automatic int model_n(input int credit);
    int lim, i, n, j;
    lim = mq.size();
    if (credit < lim) lim = credit;
    if (L < lim) lim = L;
    i = 0; n = 0;
    while (i < lim) begin
      if (mq[i].tx_begin) begin
        j = -1;
        for (int k = i; k < mq.size(); k++) begin
          if (mq[k].tx_end) begin j = k; break; end
        end
        if (j < 0 || j >= lim) break;
        n = j + 1;
        i = j + 1;
      end else begin
        n = i + 1;
        if (mq[i].op == UOP_HLT) break;
        i++;
      end
    end
    return n;
  endfunction

  task automatic step(input logic [L-1:0] mask, input uop_bundle_t b, input int credit,
                      input logic fl, output logic [L-1:0] dv, output logic acc);
    int          n;
    bit          rdy;
    uop_bundle_t exp_b;
    logic [L-1:0] exp_v;
    uop_insn     u;
    assert (credit <= L) else $error("credit above lane count");
    dec_valid_in  = mask;
    dec_uop_in    = b;
    rob_credit_in = LANE_CNT_W'(credit);
    flush_in      = fl;
    #1;
    rdy = (D - mq.size()) >= L;
    n   = (m_halted || fl) ? 0 : model_n(credit);
    exp_b = '0;
    exp_v = '0;
    for (int i = 0; i < n; i++) begin
      exp_b[i] = mq[i];
      exp_v[i] = 1'b1;
    end
    check_val("ready", dec_ready_out, rdy);
    check_val("occupancy", occupancy_out, mq.size());
    check_val("halted", halted_out, m_halted);
    check_val("disp_valid", disp_valid_out, exp_v);
    check_val("disp_uop", disp_uop_out, exp_b);
    dv  = disp_valid_out;
    acc = rdy && (|mask) && !fl;
    if (fl) begin
      mq.delete();
      m_halted = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        u = mq.pop_front();
        if (u.op == UOP_HLT) m_halted = 1'b1;
      end
      if (acc) begin
        for (int i = 0; i < L; i++) if (mask[i]) mq.push_back(b[i]);
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic refill();
    int r, len;
    r = $urandom_range(0, 19);
    if (r == 0) stream.push_back(mk(UOP_HLT, 1'b0, 1'b0));
    else if (r <= 7) begin
      len = $urandom_range(1, L);
      for (int k = 0; k < len; k++)
        stream.push_back(mk(uop_op_t'($urandom_range(1, 4)), k == 0, k == len - 1));
    end else stream.push_back(mk(uop_op_t'($urandom_range(1, 4)), 1'b0, 1'b0));
  endtask

  initial begin
    logic [L-1:0] dv;
    logic         acc;
    logic [L-1:0] cur_mask;
    uop_bundle_t  cur_b;
    bit           have;
    uop_insn      a, b;

    rst_in = 1'b1; flush_in = 1'b0;
    dec_valid_in = '1; rob_credit_in = LANE_CNT_W'(L);
    dec_uop_in = bndl(mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0));
    repeat (3) @(posedge clk_in);
    #1;
    check_val("rst_ready", dec_ready_out, 1'b0);
    check_val("rst_valid", disp_valid_out, '0);
    check_val("rst_occ", occupancy_out, '0);
    check_val("rst_halt", halted_out, 1'b0);
    rst_in = 1'b0;
    dec_valid_in = '0;
    #1;
    check_val("post_rst_ready", dec_ready_out, 1'b1);
    @(posedge clk_in);
    #1;

    // Full ADD bundle, dispatched whole the next cycle.
    step(4'hF, bndl(mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0)), 4, 0, dv, acc);
    check_val("first_lat", dv, 4'b0000);
    step(4'h0, '0, 4, 0, dv, acc);
    check_val("full_bundle", dv, 4'b1111);

    // Sparse bundle compacts.
    a = mk(UOP_ADD, 0, 0); b = mk(UOP_SUB, 0, 0);
    step(4'b1010, bndl(mk(UOP_NOP,0,0), a, mk(UOP_NOP,0,0), b), 4, 0, dv, acc);
    step(4'h0, '0, 4, 0, dv, acc);
    check_val("sparse_valid", dv, 4'b0011);

    // Fill to 29, backpressure, then drain at credit 2 across the wrap.
    for (int k = 0; k < 7; k++)
      step(4'hF, bndl(mk(UOP_ADD,0,0), mk(UOP_SUB,0,0), mk(UOP_LOAD,0,0), mk(UOP_STORE,0,0)), 0, 0, dv, acc);
    step(4'b0001, bndl(mk(UOP_ADD,0,0), '0, '0, '0), 0, 0, dv, acc);
    step(4'hF, bndl(mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0)), 0, 0, dv, acc);
    check_val("full_not_ready", dec_ready_out, 1'b0);
    check_val("full_occ", occupancy_out, 29);
    for (int k = 0; k < 4; k++) step(4'h0, '0, 2, 0, dv, acc);
    check_val("credit2", dv, 4'b0011);
    for (int k = 0; k < 2; k++)
      step(4'hF, bndl(mk(UOP_ADD,0,0), mk(UOP_SUB,0,0), mk(UOP_LOAD,0,0), mk(UOP_STORE,0,0)), 2, 0, dv, acc);
    for (int k = 0; k < 30 && mq.size() > 0; k++) step(4'h0, '0, 2, 0, dv, acc);
    check_val("drained", occupancy_out, 0);

    // Atomic group waits for enough credit.
    step(4'hF, bndl(mk(UOP_ADD,0,0), mk(UOP_LOAD,1,0), mk(UOP_STORE,0,0), mk(UOP_ADD,0,1)), 0, 0, dv, acc);
    step(4'h0, '0, 3, 0, dv, acc);
    check_val("tx_split", dv, 4'b0001);
    step(4'h0, '0, 3, 0, dv, acc);
    check_val("tx_group", dv, 4'b0111);

    // HLT serialises until flush.
    step(4'b0111, bndl(mk(UOP_SUB,0,0), mk(UOP_HLT,0,0), mk(UOP_ADD,0,0), '0), 0, 0, dv, acc);
    step(4'h0, '0, 4, 0, dv, acc);
    check_val("hlt_n", dv, 4'b0011);
    check_val("hlt_set", halted_out, 1'b1);
    check_val("hlt_occ", occupancy_out, 1);
    step(4'h0, '0, 4, 1, dv, acc);
    check_val("flush_occ", occupancy_out, 0);
    check_val("flush_halt", halted_out, 1'b0);

    // Flush drops a same-cycle decode bundle and suppresses dispatch.
    step(4'hF, bndl(mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0)), 0, 0, dv, acc);
    step(4'b0001, bndl(mk(UOP_SUB,0,0), '0, '0, '0), 0, 0, dv, acc);
    check_val("pre_flush_occ", occupancy_out, 5);
    step(4'hF, bndl(mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0), mk(UOP_ADD,0,0)), 4, 1, dv, acc);
    check_val("flush_nodisp", dv, 4'b0000);
    check_val("flush_drop", occupancy_out, 0);

    // Randomised traffic against the model.
    have = 1'b0; cur_mask = '0; cur_b = '0;
    for (int c = 0; c < 1500; c++) begin
      int  credit;
      logic fl;
      if (!have) begin
        cur_mask = L'($urandom_range(0, 15));
        cur_b = '0;
        for (int i = 0; i < L; i++) begin
          if (cur_mask[i]) begin
            if (stream.size() == 0) refill();
            cur_b[i] = stream.pop_front();
          end
        end
        have = 1'b1;
      end
      credit = ((c / 100) % 2 == 1) ? $urandom_range(0, 2) : $urandom_range(0, L);
      fl = ($urandom_range(0, 29) == 0);
      step(cur_mask, cur_b, credit, fl, dv, acc);
      if (acc || fl || cur_mask == '0) have = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
